multi_chan_accumulator: RTL

MULTI_CHAN_ACCUMULATOR -- requirements
Module: multi_chan_accumulator

---
 rtl/multi_chan_accumulator_pkg.sv | 16 +
 rtl/multi_chan_accumulator_sat_add.sv | 30 +++
 rtl/multi_chan_accumulator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/multi_chan_accumulator_pkg.sv
// Shared defaults and width helpers for the multi-channel frame accumulator.
// Every file of the block imports this package, so the defaults live in one place.
package multi_chan_accumulator_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int DEF_ACCUM_INIT = 0;

    // A single channel still needs a 1-bit channel field on the ports.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/multi_chan_accumulator_sat_add.sv
// Combinational two's-complement adder that clamps to the signed range.
// ovf is high whenever the exact sum does not fit and has been clamped.
module sat_add
    import multi_chan_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] a,
    input  logic signed [ACC_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        ovf
);

    localparam logic [ACC_WIDTH-1:0] MAX_VAL = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MIN_VAL = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] wide_sum;

    // One guard bit: overflow shows as a disagreement between the top two bits.
    assign wide_sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    assign ovf      = wide_sum[ACC_WIDTH] ^ wide_sum[ACC_WIDTH-1];

    always_comb begin
        sum = wide_sum[ACC_WIDTH-1:0];
        if (ovf) begin
            sum = wide_sum[ACC_WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/multi_chan_accumulator.sv
// Per-channel saturating accumulator: sums samples per channel and emits
// (channel, sum, count, saturated) on in_last through a one-deep output register.
module multi_chan_accumulator
    import multi_chan_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int ACCUM_INIT = DEF_ACCUM_INIT,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_W-1:0]              in_ch,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_W-1:0]              out_ch,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]         out_count,
    output logic                         out_sat
);

    localparam logic signed [ACC_WIDTH-1:0] INIT_VAL  = ACC_WIDTH'(ACCUM_INIT);
    localparam logic [CH_W:0]               NUM_CH_EXT = (CH_W+1)'(NUM_CH);

    // Channel state banks, one entry per channel, driven from the generate loop.
    logic signed [ACC_WIDTH-1:0] acc_bank [NUM_CH];
    logic [CNT_WIDTH-1:0]        cnt_bank [NUM_CH];
    logic                        sat_bank [NUM_CH];

    logic                        accept;
    logic                        ch_ok;
    logic                        upd;
    logic                        emit;
    logic [CH_W-1:0]             ch_idx;
    logic signed [ACC_WIDTH-1:0] acc_sel;
    logic [CNT_WIDTH-1:0]        cnt_sel;
    logic                        sat_sel;
    logic signed [ACC_WIDTH-1:0] data_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        ovf;
    logic [CNT_WIDTH-1:0]        cnt_next;
    logic                        sat_next;

    logic                        out_valid_reg;
    logic [CH_W-1:0]             out_ch_reg;
    logic signed [ACC_WIDTH-1:0] out_data_reg;
    logic [CNT_WIDTH-1:0]        out_count_reg;
    logic                        out_sat_reg;

    assign in_ready = rst_n && !clear && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign ch_ok    = {1'b0, in_ch} < NUM_CH_EXT;
    // Out-of-range channels are swallowed: accepted, but they touch nothing.
    assign upd      = accept && ch_ok;
    assign emit     = upd && in_last;
    assign ch_idx   = ch_ok ? in_ch : '0;

    assign acc_sel  = acc_bank[ch_idx];
    assign cnt_sel  = cnt_bank[ch_idx];
    assign sat_sel  = sat_bank[ch_idx];
    assign data_ext = ACC_WIDTH'(in_data);

    sat_add #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .a   (acc_sel),
        .b   (data_ext),
        .sum (acc_next),
        .ovf (ovf)
    );

    assign cnt_next = (&cnt_sel) ? cnt_sel : cnt_sel + 1'b1;
    assign sat_next = sat_sel | ovf;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic signed [ACC_WIDTH-1:0] acc_reg;
        logic [CNT_WIDTH-1:0]        cnt_reg;
        logic                        sat_reg;
        logic                        hit;

        assign hit = upd && (ch_idx == CH_W'(gi));

        // Emitting a frame hands the totals to the output register and restarts the channel.
        always_ff @(posedge clk) begin
            if (!rst_n || clear || (hit && in_last)) begin
                acc_reg <= INIT_VAL;
                cnt_reg <= '0;
                sat_reg <= 1'b0;
            end else if (hit) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_next;
                sat_reg <= sat_next;
            end
        end

        assign acc_bank[gi] = acc_reg;
        assign cnt_bank[gi] = cnt_reg;
        assign sat_bank[gi] = sat_reg;
    end

    // A load may coincide with a drain; in_ready already guarantees the slot is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            out_data_reg  <= INIT_VAL;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
        end else if (emit) begin
            out_valid_reg <= 1'b1;
            out_ch_reg    <= in_ch;
            out_data_reg  <= acc_next;
            out_count_reg <= cnt_next;
            out_sat_reg   <= sat_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;
    assign out_sat   = out_sat_reg;

endmodule
